comb_sweep_ctrl: RTL
====================

# comb_sweep_ctrl

Sequencer that drives the 3-input combinational lab datapath (`comb_Y1`/`comb_Y2`, ports Y,A,B,C) exhaustively through input vectors 000..111 in hardware. It holds each vector for a configurable number of cycles, captures Y into an 8-bit truth-table register and compares the result against a golden table. Start/done handshake to the board-level controller; sits between the lab top and the combinational block under test.

## Interface
- `HOLD_CYCLES`, default 2: cycles each vector is held before Y is sampled; legal range 1..255.
- `EXPECT`, default 8'hE8: golden truth table; bit k is the expected Y for ABC = k (default is 3-input majority).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request; honoured only in IDLE.
- `y_in`  in  1  Y output of the combinational block; driven combinationally from `abc`.
- `abc`  out  3  {A,B,C} driven to the combinational block.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse on sweep completion.
- `table_out`  out  8  captured truth table; bit k = Y sampled for ABC = k.
- `pass`  out  1  `table_out` == `EXPECT` for the last completed sweep.

## Operation
- States: IDLE, SWEEP. 3-bit vector index `idx`, 8-bit hold counter `hcnt`.
- Reset (async, any state): state IDLE; `abc`=000, `busy`=0, `done`=0, `table_out`=8'h00, `pass`=0, `idx`=0, `hcnt`=0.
- IDLE + `start`=1: go to SWEEP; `busy`<=1, `abc`<=000, `idx`<=0, `hcnt`<=0, `table_out`<=0, `pass`<=0, `done`<=0.
- SWEEP: `hcnt` increments each cycle; when `hcnt`==HOLD_CYCLES-1: `table_out[idx]`<=`y_in`, `hcnt`<=0; if `idx`<7 then `idx`,`abc` increment; if `idx`==7, end the sweep.
- End of sweep (same edge as sampling for idx 7): state IDLE, `busy`<=0, `done`<=1, `pass`<=({`y_in`,`table_out[6:0]`}==EXPECT). `abc` stays at 111.
- `done` is cleared on the following edge unconditionally.
- `start` while busy is ignored; no queuing. `start` held high continuously restarts immediately after each sweep.
- `table_out`, `pass` and `abc` hold their values in IDLE until the next accepted start.

## Timing
- Let E0 = edge sampling `start`=1 in IDLE. Vector k is on `abc` from E(k·H) to E((k+1)·H), H = HOLD_CYCLES.
- `y_in` for vector k is sampled at E((k+1)·H); settling budget is H cycles minus one clock-to-out.
- `done`=1 and `busy`=0 after E(8H); `done` low again after E(8H+1). Latency start→done = 8H cycles.
- Back-to-back: `start`=1 at E(8H+1) begins a new sweep; `done` falls at that same edge.
- H=1: one vector per cycle, sweep completes in 8 cycles.
- Reset mid-sweep: outputs return to reset values immediately, no `done` pulse; next sweep requires a fresh `start` after `rst_n` deasserts.

## Configuration
- `COMB_SWEEP_EARLY_STOP_EN` defined: at each sample edge, if `y_in` != `EXPECT[idx]`, the sweep ends at that edge: `done`<=1, `pass`<=0, `busy`<=0, `abc` frozen at the failing vector (gives the fail index); `table_out` bits above the failing index stay 0.
- Not defined: the full 8-vector sweep always runs; mismatches only affect `pass`.

## Test plan
- Reset: `rst_n`=0 with `start`=1 -> `abc`=000, `busy`=0, `done`=0, `table_out`=8'h00, `pass`=0; no state change while low.
- H=2, `y_in`=majority(`abc`), `start` pulse at E0 -> `abc` steps 000..111 every 2 cycles, `done` pulse after E16, `table_out`=8'hE8, `pass`=1, `abc`=111 afterwards.
- H=2, `y_in` stuck at 0 -> `done` after E16, `table_out`=8'h00, `pass`=0.
- `start` held high throughout, H=1 -> `start` pulses during sweep ignored; `done` after E8, new sweep begins at E9, second `done` after E17.
- `rst_n` pulled low while `abc`=011 -> all outputs zero asynchronously, no `done`; `start` afterwards gives a complete correct sweep.
- `COMB_SWEEP_EARLY_STOP_EN`, H=2, majority with `y_in` inverted at ABC=101 -> `done` after E12, `pass`=0, `abc`=101, `table_out`=8'h08.

Source files
------------

// File: rtl/comb_sweep_ctrl.sv
// Sweeps ABC 000..111 into a combinational block, captures Y into a truth table, and checks it against EXPECT.
// Latency: each vector is held HOLD_CYCLES cycles, so start to done takes 8*HOLD_CYCLES cycles. `start` is ignored while busy.
// Build option COMB_SWEEP_EARLY_STOP_EN ends the sweep at the first vector whose Y differs from EXPECT.
module comb_sweep_ctrl #(
  parameter int         HOLD_CYCLES = 2,
  parameter logic [7:0] EXPECT      = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic [2:0] abc,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] hcnt, hcnt_nxt;
  logic [7:0] table_nxt, table_cap;
  logic       busy_nxt, done_nxt, pass_nxt;
  logic       sample;
`ifdef COMB_SWEEP_EARLY_STOP_EN
  logic       miss;
`endif

  // The vector on abc is the index itself, so abc stops on the last (or failing) vector.
  assign abc = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      hcnt      <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= 8'h00;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      hcnt      <= hcnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      table_out <= table_nxt;
      pass      <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    hcnt_nxt       = hcnt;
    table_nxt      = table_out;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    pass_nxt       = pass;
    sample         = (hcnt == HOLD_LAST);
    table_cap      = table_out;
    table_cap[idx] = y_in;
`ifdef COMB_SWEEP_EARLY_STOP_EN
    miss           = (y_in != EXPECT[idx]);
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SWEEP;
          busy_nxt  = 1'b1;
          idx_nxt   = 3'd0;
          hcnt_nxt  = 8'd0;
          table_nxt = 8'h00;
          pass_nxt  = 1'b0;
        end
      end
      SWEEP: begin
        if (!sample) begin
          hcnt_nxt = hcnt + 8'd1;
        end else begin
          hcnt_nxt  = 8'd0;
          table_nxt = table_cap;
`ifdef COMB_SWEEP_EARLY_STOP_EN
          if (miss) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b0;
          end else
`endif
          if (idx == 3'd7) begin
            // table_cap already carries the bit-7 sample taken on this edge.
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (table_cap == EXPECT);
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
